// File: rtl/imem_load_controller.sv
// Instruction-memory ownership sequencer: loads a program word stream into RAM while
// stalling the pipeline, then serves fetches. Optional macro: IMEM_BOUNDS_CHECK_EN.
module imem_load_controller #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [15:0]   load_data,
  output logic          load_ready,
  input  logic          load_done,
  input  logic          fetch_req,
  input  logic [15:0]   fetch_pc,
  output logic          fetch_valid,
  output logic [15:0]   fetch_instr,
  output logic          stall_out,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  output logic [AW:0]   load_count,
  output logic          err_overflow,
  output logic          err_bounds,
  output logic [1:0]    dbg_state
);

  // Load port handshake: a word transfers on a cycle where load_valid && load_ready.
  // load_ready never depends on load_valid; it drops while full or while a restart is requested.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state, w_next;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_fvalid;
  logic          r_fzero;
  logic          w_full;
  logic          w_accept;
  logic          w_fetch;
  logic          w_oob;
  logic          w_unwritten;
  logic [AW-1:0] w_fidx;

  assign w_full      = (r_count == LP_DEPTH);
  assign w_fetch     = (r_state == S_RUN) && fetch_req;
  assign w_fidx      = fetch_pc[AW:1];
  assign w_unwritten = ({1'b0, w_fidx} >= r_count);
  assign w_accept    = load_ready && load_valid;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic r_bnd;
  logic w_unused_pc;
  assign w_oob       = |fetch_pc[15:AW+1];
  assign err_bounds  = r_bnd;
  assign w_unused_pc = fetch_pc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_bnd <= 1'b0;
    else if (load_start)        r_bnd <= 1'b0;
    else if (w_fetch && w_oob)  r_bnd <= 1'b1;
  end
`else
  logic w_unused_pc;
  assign w_oob       = 1'b0;
  assign err_bounds  = 1'b0;
  assign w_unused_pc = ^{fetch_pc[15:AW+1], fetch_pc[0]};
`endif

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 16'h0000;
    if (load_start) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_LOAD:  if (load_done) w_next = S_DRAIN;
        S_DRAIN: w_next = S_RUN;
        S_RUN:   w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
    // A restart request in LOAD takes the cycle to rewind the index, so no word is taken.
    if (r_state == S_LOAD && !load_start && !w_full) load_ready = 1'b1;
    if (load_ready && load_valid) begin
      mem_we    = 1'b1;
      mem_addr  = r_count[AW-1:0];
      mem_wdata = load_data;
    end else if (w_fetch) begin
      mem_addr  = w_fidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_fvalid <= 1'b0;
      r_fzero  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_fvalid <= w_fetch;
      r_fzero  <= w_unwritten || w_oob;
      if (load_start)                                   r_count <= '0;
      else if (w_accept)                                r_count <= r_count + 1'b1;
      if (load_start)                                   r_ovf <= 1'b0;
      else if (r_state == S_LOAD && load_valid && w_full) r_ovf <= 1'b1;
    end
  end

  // RAM read data arrives one cycle after the address, aligned with r_fvalid.
  assign fetch_valid  = r_fvalid;
  assign fetch_instr  = (r_fvalid && !r_fzero) ? mem_rdata : 16'h0000;
  assign stall_out    = (r_state != S_RUN);
  assign load_count   = r_count;
  assign err_overflow = r_ovf;
  assign dbg_state    = r_state;

endmodule
